// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes and the burst-slave channel FSM states.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 burst channel bundle (AW/W/B/AR/R) between burst master and memory slave.
interface axi_burst_mem_slave_if #(
  parameter int unsigned ID_W   = 1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ID_W-1:0]     S_AXI_AWID;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [7:0]          S_AXI_AWLEN;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WLAST;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [ID_W-1:0]     S_AXI_BID;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ID_W-1:0]     S_AXI_ARID;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [7:0]          S_AXI_ARLEN;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [ID_W-1:0]     S_AXI_RID;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RLAST;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_mem_bram.sv
// Word memory with a byte-enabled synchronous write port and an asynchronous read port.
module axi_mem_bram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < DW/8; b++) begin
      if (we && be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_comb rdata = mem[raddr];

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR burst responder backed by an internal word memory; write and read
// channels run independent FSMs and may be active concurrently.
module axi_burst_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_BASE_ADDR = 32'h40000000,
  parameter int unsigned C_MEM_AW           = 6
) (
  input logic                  S_AXI_ACLK,
  input logic                  S_AXI_ARESET,
  axi_burst_mem_slave_if.slave s_axi
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SH = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam logic [AW-1:0] BASE_W   = AW'(C_S_BASE_ADDR >> SH);
  localparam logic [AW-1:0] WORD_ONE = AW'(1);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [AW-1:0] w_word, w_ofs;
  logic [7:0]    w_cnt, w_len;
  logic          w_err, w_ok, w_final, w_hs, beat_err;

  logic [AW-1:0] r_word, r_src, r_ofs;
  logic [7:0]    r_left;
  logic          r_ok, ar_hs, r_hs;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata;

  // Addresses are tracked as absolute word numbers so window checks stay exact
  // when a burst crosses into or out of the decoded window.
  always_comb begin
    w_ofs    = w_word - BASE_W;
    w_ok     = (w_word >= BASE_W) && ((w_ofs >> C_MEM_AW) == '0);
    w_final  = (w_cnt == w_len);
    w_hs     = (w_state == W_DATA) && s_axi.S_AXI_WVALID;
    beat_err = !w_ok || (s_axi.S_AXI_WLAST != w_final);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next              = w_state;
    s_axi.S_AXI_AWREADY = 1'b0;
    s_axi.S_AXI_WREADY  = 1'b0;
    s_axi.S_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.S_AXI_AWREADY = 1'b1;
        if (s_axi.S_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.S_AXI_WREADY = 1'b1;
        if (s_axi.S_AXI_WVALID && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.S_AXI_BVALID = 1'b1;
        if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_word            <= '0;
      w_cnt             <= '0;
      w_len             <= '0;
      w_err             <= 1'b0;
      s_axi.S_AXI_BID   <= '0;
      s_axi.S_AXI_BRESP <= RESP_OKAY;
    end else begin
      if ((w_state == W_IDLE) && s_axi.S_AXI_AWVALID) begin
        s_axi.S_AXI_BID <= s_axi.S_AXI_AWID;
        w_word          <= s_axi.S_AXI_AWADDR >> SH;
        w_cnt           <= '0;
        w_len           <= s_axi.S_AXI_AWLEN;
        w_err           <= 1'b0;
      end
      if (w_hs) begin
        w_word <= w_word + WORD_ONE;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err | beat_err;
        if (w_final) s_axi.S_AXI_BRESP <= (w_err | beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Read side: RDATA is registered from the async port, so the port address is
  // the burst start while idle and the following word while streaming.
  always_comb begin
    ar_hs = (r_state == R_IDLE) && s_axi.S_AXI_ARVALID;
    r_hs  = (r_state == R_DATA) && s_axi.S_AXI_RREADY;
    r_src = (r_state == R_IDLE) ? (s_axi.S_AXI_ARADDR >> SH) : (r_word + WORD_ONE);
    r_ofs = r_src - BASE_W;
    r_ok  = (r_src >= BASE_W) && ((r_ofs >> C_MEM_AW) == '0);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  always_comb begin
    r_next              = r_state;
    s_axi.S_AXI_ARREADY = 1'b0;
    s_axi.S_AXI_RVALID  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.S_AXI_ARREADY = 1'b1;
        if (s_axi.S_AXI_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi.S_AXI_RVALID = 1'b1;
        if (s_axi.S_AXI_RREADY && s_axi.S_AXI_RLAST) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_word            <= '0;
      r_left            <= '0;
      s_axi.S_AXI_RID   <= '0;
      s_axi.S_AXI_RDATA <= '0;
      s_axi.S_AXI_RRESP <= RESP_OKAY;
      s_axi.S_AXI_RLAST <= 1'b0;
    end else begin
      if (ar_hs) begin
        s_axi.S_AXI_RID   <= s_axi.S_AXI_ARID;
        r_word            <= r_src;
        r_left            <= s_axi.S_AXI_ARLEN;
        s_axi.S_AXI_RLAST <= (s_axi.S_AXI_ARLEN == 8'd0);
      end else if (r_hs) begin
        if (s_axi.S_AXI_RLAST) begin
          s_axi.S_AXI_RLAST <= 1'b0;
        end else begin
          r_word            <= r_src;
          r_left            <= r_left - 8'd1;
          s_axi.S_AXI_RLAST <= (r_left == 8'd1);
        end
      end
      if (ar_hs || (r_hs && !s_axi.S_AXI_RLAST)) begin
        s_axi.S_AXI_RDATA <= r_ok ? mem_rdata : '0;
        s_axi.S_AXI_RRESP <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axi_mem_bram #(
    .AW (C_MEM_AW),
    .DW (C_S_AXI_DATA_WIDTH)
  ) u_mem (
    .clk   (S_AXI_ACLK),
    .we    (w_hs && w_ok),
    .be    (s_axi.S_AXI_WSTRB),
    .waddr (C_MEM_AW'(w_ofs)),
    .wdata (s_axi.S_AXI_WDATA),
    .raddr (C_MEM_AW'(r_ofs)),
    .rdata (mem_rdata)
  );

endmodule
